alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Execute-stage wrapper sitting directly upstream and downstream of the combinational ALU.
- Upstream side: registers decoded ops (ID/EX), resolves operand forwarding from MEM/WB, and drives ALU_Sel/operand_0/operand_1.
- Downstream side: captures the ALU result into an EX/MEM output register.
- valid/ready handshake on both sides, plus flush support.

Parameters:
- DATA_W, 32, operand/result width
- REG_ADDR_W, 5, register-file address width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decoded op present
- in_ready  out  1  stage accepts op this cycle
- in_alu_sel  in  4  ALU op: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8
- in_rs1_addr  in  REG_ADDR_W  source 1 index
- in_rs2_addr  in  REG_ADDR_W  source 2 index
- in_rs1_data  in  DATA_W  register-file value rs1
- in_rs2_data  in  DATA_W  register-file value rs2
- in_imm  in  DATA_W  immediate
- in_use_imm  in  1  operand_1 = imm instead of rs2
- in_rd_addr  in  REG_ADDR_W  destination index
- in_rd_we  in  1  op writes rd
- flush  in  1  kill op held in EX register
- fwd_mem_we  in  1  MEM stage writes
- fwd_mem_rd  in  REG_ADDR_W  MEM destination
- fwd_mem_data  in  DATA_W  MEM value
- fwd_wb_we  in  1  WB stage writes
- fwd_wb_rd  in  REG_ADDR_W  WB destination
- fwd_wb_data  in  DATA_W  WB value
- alu_sel  out  4  to ALU ALU_Sel
- alu_operand_0  out  DATA_W  to ALU operand_0
- alu_operand_1  out  DATA_W  to ALU operand_1
- alu_result  in  DATA_W  from ALU result
- out_valid  out  1  EX/MEM register holds result
- out_ready  in  1  downstream consumes
- out_result  out  DATA_W  registered ALU result
- out_rd_addr  out  REG_ADDR_W  registered rd
- out_rd_we  out  1  registered rd write enable

Behaviour:
- Reset (async, rst_n=0) clears ex_valid and out_valid. All EX fields and out_result/out_rd_addr/out_rd_we reset to 0. alu_sel resets to 0 (ADD).
- Two-entry pipe: EX register then OUT register. Latency 2 edges from accepted in_valid to out_valid=1. Full throughput of 1 op/cycle when out_ready=1.
- advance = ex_valid && (!out_valid || out_ready).
- in_ready = !flush && (!ex_valid || advance), combinational.
- Accept = in_valid && in_ready. EX register loads all in_* fields; ex_valid<=1.
- When not accepting and advance (or flush), ex_valid<=0. Otherwise EX register holds.
- ALU drive is combinational from the EX register:
  - alu_sel = ex_alu_sel.
  - alu_operand_0 = fwd(rs1).
  - alu_operand_1 = ex_use_imm ? ex_imm : fwd(rs2).
- fwd(rsN) is selected in priority order:
  1. fwd_mem_data when fwd_mem_we && fwd_mem_rd==rsN && rsN!=0.
  2. Else fwd_wb_data when fwd_wb_we && fwd_wb_rd==rsN && rsN!=0.
  3. Else the registered ex_rsN_data.
- Forwarding is re-evaluated every cycle while stalled. The value captured into OUT is the one present on the advance edge.
- On advance: out_result<=alu_result, out_rd_addr<=ex_rd_addr, out_rd_we<=ex_rd_we && (ex_rd_addr!=0), out_valid<=1.
- When out_valid && out_ready && !advance: out_valid<=0.
- Stall: OUT register holds while out_valid && !out_ready. EX register holds and in_ready=0 when it is also full.
- Flush:
  - Kills the EX entry only: ex_valid<=0, no advance into OUT that cycle.
  - The OUT entry is older and is unaffected.
  - in_valid during flush is not accepted.
- ALU_Sel values 9-15 pass through unchanged; the result is whatever the ALU produces.
- Reset mid-operation discards both entries immediately.

Optional Feature:
- Macro ALU_FWD_EN.
- Defined: forwarding muxes as above.
- Undefined: fwd(rsN)=ex_rsN_data. fwd_* ports remain present but unused, and software or the hazard unit must stall instead.

Test Plan:
- Single ADD: rs1_data=5, rs2_data=7, no fwd, out_ready=1 -> out_valid on 2nd edge after accept, out_result=12.
- Immediate SRA: rs1=0x80000000, use_imm=1, imm=4, sel=7 -> out_result=0xF8000000.
- Forward priority: rs1_addr=3, rs1_data=1; MEM rd=3 data=100; WB rd=3 data=200 -> operand_0=100.
  - Repeat with MEM disabled -> operand_0=200.
  - Repeat with rs1_addr=0 -> operand_0=1.
- Backpressure: 3 back-to-back ops, out_ready=0 for 4 cycles -> in_ready falls after 2 accepted, no op lost or duplicated, results in order once out_ready=1.
- Flush: op A in OUT with out_ready=0, op B in EX, flush=1 with in_valid=1 -> A retained; B and new input dropped; next out_valid carries only A.
- Async reset while out_valid=1 -> out_valid=0 and in_ready=1 without a clock edge.

Source files
------------

// File: rtl/alu_issue_stage.sv
// Execute-stage wrapper around a combinational ALU: ID/EX register with operand forwarding,
// EX/MEM output register, valid/ready on both sides. Define ALU_FWD_EN to enable forwarding.
module alu_issue_stage #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_alu_sel,
  input  logic [REG_ADDR_W-1:0] in_rs1_addr,
  input  logic [REG_ADDR_W-1:0] in_rs2_addr,
  input  logic [DATA_W-1:0]     in_rs1_data,
  input  logic [DATA_W-1:0]     in_rs2_data,
  input  logic [DATA_W-1:0]     in_imm,
  input  logic                  in_use_imm,
  input  logic [REG_ADDR_W-1:0] in_rd_addr,
  input  logic                  in_rd_we,
  input  logic                  flush,
  input  logic                  fwd_mem_we,
  input  logic [REG_ADDR_W-1:0] fwd_mem_rd,
  input  logic [DATA_W-1:0]     fwd_mem_data,
  input  logic                  fwd_wb_we,
  input  logic [REG_ADDR_W-1:0] fwd_wb_rd,
  input  logic [DATA_W-1:0]     fwd_wb_data,
  output logic [3:0]            alu_sel,
  output logic [DATA_W-1:0]     alu_operand_0,
  output logic [DATA_W-1:0]     alu_operand_1,
  input  logic [DATA_W-1:0]     alu_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_result,
  output logic [REG_ADDR_W-1:0] out_rd_addr,
  output logic                  out_rd_we
);

  logic                  ex_valid_q;
  logic [3:0]            ex_alu_sel_q;
  logic [REG_ADDR_W-1:0] ex_rs1_addr_q;
  logic [REG_ADDR_W-1:0] ex_rs2_addr_q;
  logic [DATA_W-1:0]     ex_rs1_data_q;
  logic [DATA_W-1:0]     ex_rs2_data_q;
  logic [DATA_W-1:0]     ex_imm_q;
  logic                  ex_use_imm_q;
  logic [REG_ADDR_W-1:0] ex_rd_addr_q;
  logic                  ex_rd_we_q;

  logic                  out_valid_q;
  logic [DATA_W-1:0]     out_result_q;
  logic [REG_ADDR_W-1:0] out_rd_addr_q;
  logic                  out_rd_we_q;

  logic                  advance;
  logic                  accept;
  logic [DATA_W-1:0]     fwd_rs1;
  logic [DATA_W-1:0]     fwd_rs2;

  // A flushed EX entry must never reach OUT, so flush also blocks advance.
  assign advance  = ex_valid_q && (!out_valid_q || out_ready) && !flush;
  assign in_ready = !flush && (!ex_valid_q || advance);
  assign accept   = in_valid && in_ready;

`ifdef ALU_FWD_EN
  always_comb begin
    fwd_rs1 = ex_rs1_data_q;
    if (fwd_mem_we && (fwd_mem_rd == ex_rs1_addr_q) && (ex_rs1_addr_q != '0)) begin
      fwd_rs1 = fwd_mem_data;
    end else if (fwd_wb_we && (fwd_wb_rd == ex_rs1_addr_q) && (ex_rs1_addr_q != '0)) begin
      fwd_rs1 = fwd_wb_data;
    end
  end

  always_comb begin
    fwd_rs2 = ex_rs2_data_q;
    if (fwd_mem_we && (fwd_mem_rd == ex_rs2_addr_q) && (ex_rs2_addr_q != '0)) begin
      fwd_rs2 = fwd_mem_data;
    end else if (fwd_wb_we && (fwd_wb_rd == ex_rs2_addr_q) && (ex_rs2_addr_q != '0)) begin
      fwd_rs2 = fwd_wb_data;
    end
  end
`else
  // Without forwarding the hazard unit stalls instead; bypass inputs are deliberately ignored.
  logic unused_fwd;
  assign unused_fwd = ^{fwd_mem_we, fwd_mem_rd, fwd_mem_data, fwd_wb_we, fwd_wb_rd,
                        fwd_wb_data, ex_rs1_addr_q, ex_rs2_addr_q};
  assign fwd_rs1 = ex_rs1_data_q;
  assign fwd_rs2 = ex_rs2_data_q;
`endif

  assign alu_sel       = ex_alu_sel_q;
  assign alu_operand_0 = fwd_rs1;
  assign alu_operand_1 = ex_use_imm_q ? ex_imm_q : fwd_rs2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q    <= 1'b0;
      ex_alu_sel_q  <= '0;
      ex_rs1_addr_q <= '0;
      ex_rs2_addr_q <= '0;
      ex_rs1_data_q <= '0;
      ex_rs2_data_q <= '0;
      ex_imm_q      <= '0;
      ex_use_imm_q  <= 1'b0;
      ex_rd_addr_q  <= '0;
      ex_rd_we_q    <= 1'b0;
    end else if (accept) begin
      ex_valid_q    <= 1'b1;
      ex_alu_sel_q  <= in_alu_sel;
      ex_rs1_addr_q <= in_rs1_addr;
      ex_rs2_addr_q <= in_rs2_addr;
      ex_rs1_data_q <= in_rs1_data;
      ex_rs2_data_q <= in_rs2_data;
      ex_imm_q      <= in_imm;
      ex_use_imm_q  <= in_use_imm;
      ex_rd_addr_q  <= in_rd_addr;
      ex_rd_we_q    <= in_rd_we;
    end else if (advance || flush) begin
      ex_valid_q    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_rd_addr_q <= '0;
      out_rd_we_q   <= 1'b0;
    end else if (advance) begin
      out_valid_q   <= 1'b1;
      out_result_q  <= alu_result;
      out_rd_addr_q <= ex_rd_addr_q;
      out_rd_we_q   <= ex_rd_we_q && (ex_rd_addr_q != '0);
    end else if (out_valid_q && out_ready) begin
      out_valid_q   <= 1'b0;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_result  = out_result_q;
  assign out_rd_addr = out_rd_addr_q;
  assign out_rd_we   = out_rd_we_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: ALU model in the environment, queue-based scoreboard of
// accepted ops, and hand-computed literal checks. Honours ALU_FWD_EN like the design.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_alu_sel = '0;
  logic [4:0]  in_rs1_addr = '0, in_rs2_addr = '0, in_rd_addr = '0;
  logic [31:0] in_rs1_data = '0, in_rs2_data = '0, in_imm = '0;
  logic        in_use_imm = 1'b0, in_rd_we = 1'b0, flush = 1'b0;
  logic        fwd_mem_we = 1'b0, fwd_wb_we = 1'b0;
  logic [4:0]  fwd_mem_rd = '0, fwd_wb_rd = '0;
  logic [31:0] fwd_mem_data = '0, fwd_wb_data = '0;
  logic [3:0]  alu_sel;
  logic [31:0] alu_operand_0, alu_operand_1, alu_result;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [4:0]  out_rd_addr;
  logic        out_rd_we;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        we;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_sel(in_alu_sel), .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_use_imm(in_use_imm), .in_rd_addr(in_rd_addr), .in_rd_we(in_rd_we), .flush(flush),
    .fwd_mem_we(fwd_mem_we), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
    .fwd_wb_we(fwd_wb_we), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
    .alu_sel(alu_sel), .alu_operand_0(alu_operand_0), .alu_operand_1(alu_operand_1),
    .alu_result(alu_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd_addr(out_rd_addr), .out_rd_we(out_rd_we)
  );

  // Undefined selects produce an arbitrary but recognisable value.
  function automatic logic [31:0] alu_f(input logic [3:0] sel, input logic [31:0] a,
                                        input logic [31:0] b);
    case (sel)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[4:0];
      4'd6:    return a >> b[4:0];
      4'd7:    return $signed(a) >>> b[4:0];
      4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return a ^ b ^ 32'h5A5A5A5A;
    endcase
  endfunction

  assign alu_result = alu_f(alu_sel, alu_operand_0, alu_operand_1);

  function automatic logic [31:0] fwd_m(input logic [4:0] addr, input logic [31:0] data);
`ifdef ALU_FWD_EN
    if (addr != 0 && fwd_mem_we && fwd_mem_rd == addr) return fwd_mem_data;
    if (addr != 0 && fwd_wb_we && fwd_wb_rd == addr) return fwd_wb_data;
`endif
    return data;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: the pipe holds at most two ops, so a full pipe accepts only if OUT drains.
  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      chk("in_ready", {31'b0, in_ready},
          {31'b0, !flush && (exp_q.size() < 2 || out_ready)});
      if (out_valid && exp_q.size() == 0) chk("spurious_out_valid", 32'd1, 32'd0);
      if (out_valid && out_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out_result", out_result, e.res);
        chk("out_rd_addr", {27'b0, out_rd_addr}, {27'b0, e.rd});
        chk("out_rd_we", {31'b0, out_rd_we}, {31'b0, e.we});
      end
      if (in_valid && in_ready) begin
        e.res = alu_f(in_alu_sel, fwd_m(in_rs1_addr, in_rs1_data),
                      in_use_imm ? in_imm : fwd_m(in_rs2_addr, in_rs2_data));
        e.rd  = in_rd_addr;
        e.we  = in_rd_we && (in_rd_addr != 0);
        exp_q.push_back(e);
      end
    end
  end

  task automatic issue(input logic [3:0] sel, input logic [4:0] r1a, input logic [31:0] r1d,
                       input logic [4:0] r2a, input logic [31:0] r2d, input logic [31:0] imm,
                       input logic use_imm, input logic [4:0] rd, input logic we);
    bit ok = 0;
    in_alu_sel = sel; in_rs1_addr = r1a; in_rs1_data = r1d; in_rs2_addr = r2a;
    in_rs2_data = r2d; in_imm = imm; in_use_imm = use_imm; in_rd_addr = rd; in_rd_we = we;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("issue_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Called right after issue() returns with an idle pipe and out_ready=1.
  task automatic expect_next(input string name, input logic [31:0] res, input logic we);
    @(negedge clk);
    chk({name, "_lat1_valid"}, {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    chk({name, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({name, "_result"}, out_result, res);
    chk({name, "_rd_we"}, {31'b0, out_rd_we}, {31'b0, we});
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_alu_sel", {28'b0, alu_sel}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    issue(4'd0, 5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 1'b0, 5'd4, 1'b1);
    expect_next("add", 32'd12, 1'b1);
    drain();
    issue(4'd7, 5'd1, 32'h80000000, 5'd2, 32'd0, 32'd4, 1'b1, 5'd5, 1'b1);
    expect_next("sra_imm", 32'hF8000000, 1'b1);
    drain();
    issue(4'd1, 5'd1, 32'd10, 5'd2, 32'd100, 32'd3, 1'b1, 5'd6, 1'b1);
    expect_next("sub_imm", 32'd7, 1'b1);
    drain();
    issue(4'd8, 5'd1, 32'hFFFFFFFD, 5'd2, 32'd2, 32'd0, 1'b0, 5'd0, 1'b1);
    expect_next("slt_rd0", 32'd1, 1'b0);
    drain();
    issue(4'd12, 5'd1, 32'h0F0F0000, 5'd2, 32'h000000FF, 32'd0, 1'b0, 5'd7, 1'b1);
    expect_next("sel12", 32'h55555AA5, 1'b1);
    drain();

    fwd_mem_we = 1'b1; fwd_mem_rd = 5'd3; fwd_mem_data = 32'd100;
    fwd_wb_we = 1'b1; fwd_wb_rd = 5'd3; fwd_wb_data = 32'd200;
    issue(4'd0, 5'd3, 32'd1, 5'd0, 32'd0, 32'd0, 1'b0, 5'd8, 1'b1);
    @(negedge clk);
`ifdef ALU_FWD_EN
    chk("fwd_mem_prio", alu_operand_0, 32'd100);
`else
    chk("fwd_mem_prio", alu_operand_0, 32'd1);
`endif
    drain();
    fwd_mem_we = 1'b0;
    issue(4'd0, 5'd3, 32'd1, 5'd0, 32'd0, 32'd0, 1'b0, 5'd8, 1'b1);
    @(negedge clk);
`ifdef ALU_FWD_EN
    chk("fwd_wb", alu_operand_0, 32'd200);
`else
    chk("fwd_wb", alu_operand_0, 32'd1);
`endif
    drain();
    fwd_mem_we = 1'b1; fwd_mem_rd = 5'd0; fwd_wb_rd = 5'd0;
    issue(4'd0, 5'd0, 32'd1, 5'd0, 32'd0, 32'd0, 1'b0, 5'd8, 1'b1);
    @(negedge clk);
    chk("fwd_x0", alu_operand_0, 32'd1);
    drain();
    fwd_mem_we = 1'b0; fwd_wb_we = 1'b0;

    // Backpressure: three back-to-back ops against a stalled consumer.
    out_ready = 1'b0;
    fork
      begin
        issue(4'd0, 5'd1, 32'd1, 5'd2, 32'd10, 32'd0, 1'b0, 5'd11, 1'b1);
        issue(4'd2, 5'd1, 32'hF0F0, 5'd2, 32'hFF00, 32'd0, 1'b0, 5'd12, 1'b1);
        issue(4'd5, 5'd1, 32'd3, 5'd2, 32'd4, 32'd0, 1'b0, 5'd13, 1'b1);
      end
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_all_drained", exp_q.size(), 32'd0);

    // Flush: A sits in OUT, B in EX, new op C offered during flush.
    out_ready = 1'b0;
    issue(4'd0, 5'd1, 32'd20, 5'd2, 32'd22, 32'd0, 1'b0, 5'd14, 1'b1);
    issue(4'd0, 5'd1, 32'd30, 5'd2, 32'd33, 32'd0, 1'b0, 5'd15, 1'b1);
    flush = 1'b1;
    in_alu_sel = 4'd0; in_rs1_data = 32'd40; in_rs2_data = 32'd44; in_rd_addr = 5'd16;
    in_valid = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    void'(exp_q.pop_back());
    @(negedge clk);
    chk("flush_a_kept_valid", {31'b0, out_valid}, 32'd1);
    chk("flush_a_kept_result", out_result, 32'd42);
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    chk("flush_a_out", out_result, 32'd42);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("flush_no_more", {31'b0, out_valid}, 32'd0);
    end

    // Async reset with a result parked in OUT.
    out_ready = 1'b0;
    issue(4'd4, 5'd1, 32'hAA, 5'd2, 32'h55, 32'd0, 1'b0, 5'd17, 1'b1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("arst_out_result", out_result, 32'd0);
    exp_q.delete();
    out_ready = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", {31'b0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
